// File: rtl/out_layer_mac_if.sv
// Handshake bundle between the hidden-layer node and the output-layer MAC:
// activations and weights in, saturated results out.
interface out_layer_mac_if #(
  parameter int IN_SIZE = 5,
  parameter int OUT_W   = 17
);
  localparam int ZW = 2*IN_SIZE+2;

  logic                      z_valid;
  logic                      z_take;
  logic signed [ZW-1:0]      z4, z5, z6, z7;
  logic signed [IN_SIZE-1:0] w48, w58, w68, w78;
  logic signed [IN_SIZE-1:0] w49, w59, w69, w79;
  logic signed [OUT_W-1:0]   out0, out1;
  logic                      out_valid;
  logic                      out_ready;
  logic                      overrun;

  modport slave (
    input  z_valid, z4, z5, z6, z7,
    input  w48, w58, w68, w78, w49, w59, w69, w79,
    input  out_ready,
    output z_take, out0, out1, out_valid, overrun
  );

  modport master (
    output z_valid, z4, z5, z6, z7,
    output w48, w58, w68, w78, w49, w59, w69, w79,
    output out_ready,
    input  z_take, out0, out1, out_valid, overrun
  );
endinterface

// File: rtl/out_layer_mac.sv
// Output-layer MAC: one time-shared signed multiplier computes out0 and out1
// over 8 cycles, then presents both saturated results under valid/ready.
module out_layer_mac #(
  parameter int IN_SIZE = 5,
  parameter int OUT_W   = 17
) (
  input  logic            clk,
  input  logic            rst_n,
  out_layer_mac_if.slave  bus
);
  localparam int ZW    = 2*IN_SIZE+2;
  localparam int ACC_W = 3*IN_SIZE+4;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (OUT_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

  typedef enum logic [1:0] {IDLE, MAC0, MAC1, DONE} state_t;

  state_t                          state_q, state_d;
  logic [1:0]                      idx_q, idx_d;
  logic signed [ACC_W-1:0]         acc_q, acc_d;
  logic signed [OUT_W-1:0]         res0_q, res0_d;
  logic signed [OUT_W-1:0]         out0_q, out0_d, out1_q, out1_d;
  logic                            out_valid_q, out_valid_d;
  logic                            overrun_q, overrun_d;
  logic [3:0][ZW-1:0]              z_q, z_d;
  logic [3:0][IN_SIZE-1:0]         w8_q, w8_d, w9_q, w9_d;

  logic signed [ZW-1:0]            z_sel;
  logic signed [IN_SIZE-1:0]       w_sel;
  logic signed [ACC_W-1:0]         prod, sum;

  function automatic logic signed [OUT_W-1:0] sat(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[OUT_W-1:0];
    else if (v < SAT_MIN) return SAT_MIN[OUT_W-1:0];
    else                  return v[OUT_W-1:0];
  endfunction

  // Operands are sign-extended to ACC_W before the multiply so the product is exact.
  assign z_sel = z_q[idx_q];
  assign w_sel = (state_q == MAC1) ? w9_q[idx_q] : w8_q[idx_q];
  assign prod  = ACC_W'(z_sel) * ACC_W'(w_sel);
  assign sum   = acc_q + prod;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    res0_d      = res0_q;
    out0_d      = out0_q;
    out1_d      = out1_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q | (bus.z_valid & (state_q != IDLE));
    z_d         = z_q;
    w8_d        = w8_q;
    w9_d        = w9_q;
    case (state_q)
      IDLE: if (bus.z_valid) begin
        z_d     = {bus.z7, bus.z6, bus.z5, bus.z4};
        w8_d    = {bus.w78, bus.w68, bus.w58, bus.w48};
        w9_d    = {bus.w79, bus.w69, bus.w59, bus.w49};
        acc_d   = '0;
        idx_d   = '0;
        state_d = MAC0;
      end
      MAC0: if (idx_q == 2'd3) begin
        res0_d  = sat(sum);
        acc_d   = '0;
        idx_d   = '0;
        state_d = MAC1;
      end else begin
        acc_d = sum;
        idx_d = idx_q + 2'd1;
      end
      MAC1: if (idx_q == 2'd3) begin
        out0_d      = res0_q;
        out1_d      = sat(sum);
        out_valid_d = 1'b1;
        acc_d       = '0;
        idx_d       = '0;
        state_d     = DONE;
      end else begin
        acc_d = sum;
        idx_d = idx_q + 2'd1;
      end
      DONE: if (bus.out_ready) begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      res0_q      <= '0;
      out0_q      <= '0;
      out1_q      <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      z_q         <= '0;
      w8_q        <= '0;
      w9_q        <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      res0_q      <= res0_d;
      out0_q      <= out0_d;
      out1_q      <= out1_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      z_q         <= z_d;
      w8_q        <= w8_d;
      w9_q        <= w9_d;
    end
  end

  assign bus.z_take    = (state_q == IDLE);
  assign bus.out0      = out0_q;
  assign bus.out1      = out1_q;
  assign bus.out_valid = out_valid_q;
  assign bus.overrun   = overrun_q;
endmodule
